// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: ALU opcode width and encodings.
package sap1_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] ALU_NOP   = 4'h0;
  localparam logic [OPCODE_W-1:0] ALU_RESET = 4'h1;
  localparam logic [OPCODE_W-1:0] ALU_REGA  = 4'h2;
  localparam logic [OPCODE_W-1:0] ALU_ADD   = 4'h3;
  localparam logic [OPCODE_W-1:0] ALU_SUB   = 4'h4;
  localparam logic [OPCODE_W-1:0] ALU_AND   = 4'h5;
  localparam logic [OPCODE_W-1:0] ALU_OR    = 4'h6;
  localparam logic [OPCODE_W-1:0] ALU_XOR   = 4'h7;
  localparam logic [OPCODE_W-1:0] ALU_NOT   = 4'h8;
  localparam logic [OPCODE_W-1:0] ALU_SHL   = 4'h9;
  localparam logic [OPCODE_W-1:0] ALU_SHR   = 4'hA;
  localparam logic [OPCODE_W-1:0] ALU_OUT   = 4'hB;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: next accumulator value and next carry/borrow flag.
// Opcodes that do not touch ACC (NOP, REGA, OUT, reserved) pass the current state through.
module alu_core
  import sap1_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_acc,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic                  i_ovf,
  input  logic [OPCODE_W-1:0]   i_opcode,
  output logic [DATA_WIDTH-1:0] o_acc_next,
  output logic                  o_ovf_next
);

  logic [DATA_WIDTH:0] w_sum;

  assign w_sum = {1'b0, i_acc} + {1'b0, i_a};

  // Opcode decode; hold is the default so only ACC-modifying ops are listed.
  always_comb begin
    o_acc_next = i_acc;
    o_ovf_next = i_ovf;
    case (i_opcode)
      ALU_RESET: begin
        o_acc_next = '0;
        o_ovf_next = 1'b0;
      end
      ALU_ADD: {o_ovf_next, o_acc_next} = w_sum;
      ALU_SUB: begin
        o_acc_next = i_acc - i_a;
        o_ovf_next = (i_a > i_acc);
      end
      ALU_AND: begin
        o_acc_next = i_acc & i_a;
        o_ovf_next = 1'b0;
      end
      ALU_OR: begin
        o_acc_next = i_acc | i_a;
        o_ovf_next = 1'b0;
      end
      ALU_XOR: begin
        o_acc_next = i_acc ^ i_a;
        o_ovf_next = 1'b0;
      end
      ALU_NOT: begin
        o_acc_next = ~i_acc;
        o_ovf_next = 1'b0;
      end
      ALU_SHL: {o_ovf_next, o_acc_next} = {i_acc, 1'b0};
      ALU_SHR: begin
        o_acc_next = {1'b0, i_acc[DATA_WIDTH-1:1]};
        o_ovf_next = i_acc[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu.sv
// SAP-1 accumulator ALU: owns operand A, ACC, carry/borrow flag and the output register.
module alu
  import sap1_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  a_reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [OPCODE_W-1:0]   opcode,
  output logic                  acc_overflow,
  output logic                  acc_zero,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_ovf;
  logic [DATA_WIDTH-1:0] w_acc_next;
  logic                  w_ovf_next;

  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .i_acc      (r_acc),
    .i_a        (r_a),
    .i_ovf      (r_ovf),
    .i_opcode   (opcode),
    .o_acc_next (w_acc_next),
    .o_ovf_next (w_ovf_next)
  );

  // Operand register, loaded only by REGA.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n)              r_a <= '0;
    else if (opcode == ALU_REGA) r_a <= data_in;
  end

  // Accumulator and flag follow the core every cycle; the core holds them for non-ACC ops.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      r_ovf <= w_ovf_next;
    end
  end

  // Output register publishes ACC only on OUT.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n)             r_data_out <= '0;
    else if (opcode == ALU_OUT) r_data_out <= r_acc;
  end

  assign acc_zero     = (r_acc == '0);
  assign acc_overflow = r_ovf;
  assign data_out     = r_data_out;

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  import sap1_pkg::*;

  logic       clk;
  logic       a_reset_n;
  logic [7:0] data_in;
  logic [3:0] opcode;
  logic       acc_overflow;
  logic       acc_zero;
  logic [7:0] data_out;

  int total;
  int bad;

  typedef struct {
    logic [3:0] op;
    logic [7:0] out;
    logic       ovf;
    logic       zero;
  } exp_t;

  exp_t exp_q[$];

  int m_a, m_acc, m_out, m_ovf;

  alu #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .a_reset_n    (a_reset_n),
    .data_in      (data_in),
    .opcode       (opcode),
    .acc_overflow (acc_overflow),
    .acc_zero     (acc_zero),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Scoreboard: one expected entry per issued opcode, checked just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total += 3;
      if (data_out !== e.out) begin
        bad++;
        $display("FAIL sb_data_out op=%h: got %h want %h", e.op, data_out, e.out);
      end
      if (acc_overflow !== e.ovf) begin
        bad++;
        $display("FAIL sb_overflow op=%h: got %b want %b", e.op, acc_overflow, e.ovf);
      end
      if (acc_zero !== e.zero) begin
        bad++;
        $display("FAIL sb_zero op=%h: got %b want %b", e.op, acc_zero, e.zero);
      end
    end
  end

  task automatic model_reset();
    m_a = 0; m_acc = 0; m_out = 0; m_ovf = 0;
  endtask

  // Drive one opcode, advance the reference model, queue the expectation, wait past the edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] din);
    exp_t e;
    @(negedge clk);
    opcode  = op;
    data_in = din;
    case (op)
      4'h1: begin m_acc = 0; m_ovf = 0; end
      4'h2: m_a = int'(din);
      4'h3: begin m_ovf = (m_acc + m_a > 255) ? 1 : 0; m_acc = (m_acc + m_a) % 256; end
      4'h4: begin m_ovf = (m_a > m_acc) ? 1 : 0; m_acc = (m_acc - m_a + 256) % 256; end
      4'h5: begin m_acc = m_acc & m_a; m_ovf = 0; end
      4'h6: begin m_acc = m_acc | m_a; m_ovf = 0; end
      4'h7: begin m_acc = m_acc ^ m_a; m_ovf = 0; end
      4'h8: begin m_acc = 255 - m_acc; m_ovf = 0; end
      4'h9: begin m_ovf = (m_acc >= 128) ? 1 : 0; m_acc = (m_acc * 2) % 256; end
      4'hA: begin m_ovf = m_acc % 2; m_acc = m_acc / 2; end
      4'hB: m_out = m_acc;
      default: ;
    endcase
    e.op   = op;
    e.out  = 8'(m_out);
    e.ovf  = (m_ovf != 0);
    e.zero = (m_acc == 0);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    a_reset_n = 1'b0;
    opcode    = ALU_NOP;
    data_in   = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    total += 3;
    if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    if (acc_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", acc_overflow); end
    if (acc_zero !== 1'b1) begin bad++; $display("FAIL reset_zero: got %b want 1", acc_zero); end
    @(negedge clk);
    a_reset_n = 1'b1;
  endtask

  task automatic test_logic_chain();
    issue(ALU_RESET, 8'h00);
    issue(ALU_REGA, 8'h0F); issue(ALU_ADD, 8'h00); issue(ALU_OUT, 8'h00);
    total++;
    if (data_out !== 8'h0F) begin bad++; $display("FAIL chain_add: got %h want 0f", data_out); end
    issue(ALU_REGA, 8'hAA); issue(ALU_AND, 8'h00); issue(ALU_OUT, 8'h00);
    total++;
    if (data_out !== 8'h0A) begin bad++; $display("FAIL chain_and: got %h want 0a", data_out); end
    issue(ALU_REGA, 8'h05); issue(ALU_OR, 8'h00); issue(ALU_OUT, 8'h00);
    total++;
    if (data_out !== 8'h0F) begin bad++; $display("FAIL chain_or: got %h want 0f", data_out); end
    issue(ALU_REGA, 8'h0F); issue(ALU_SUB, 8'h00);
    total += 2;
    if (acc_zero !== 1'b1) begin bad++; $display("FAIL chain_sub_zero: got %b want 1", acc_zero); end
    if (acc_overflow !== 1'b0) begin bad++; $display("FAIL chain_sub_ovf: got %b want 0", acc_overflow); end
    issue(ALU_OUT, 8'h00);
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL chain_out: got %h want 00", data_out); end
  endtask

  task automatic test_borrow();
    issue(ALU_RESET, 8'h00);
    issue(ALU_REGA, 8'h0F); issue(ALU_ADD, 8'h00);
    issue(ALU_REGA, 8'h10); issue(ALU_SUB, 8'h00); issue(ALU_OUT, 8'h00);
    total += 3;
    if (data_out !== 8'hFF) begin bad++; $display("FAIL borrow_out: got %h want ff", data_out); end
    if (acc_overflow !== 1'b1) begin bad++; $display("FAIL borrow_ovf: got %b want 1", acc_overflow); end
    if (acc_zero !== 1'b0) begin bad++; $display("FAIL borrow_zero: got %b want 0", acc_zero); end
  endtask

  task automatic test_carry();
    issue(ALU_RESET, 8'h00);
    issue(ALU_REGA, 8'hF0); issue(ALU_ADD, 8'h00);
    issue(ALU_REGA, 8'h20); issue(ALU_ADD, 8'h00);
    total++;
    if (acc_overflow !== 1'b1) begin bad++; $display("FAIL carry_ovf: got %b want 1", acc_overflow); end
    issue(ALU_OUT, 8'h00);
    total++;
    if (data_out !== 8'h10) begin bad++; $display("FAIL carry_sum: got %h want 10", data_out); end
    issue(ALU_AND, 8'h00);
    total++;
    if (acc_overflow !== 1'b0) begin bad++; $display("FAIL carry_and_clear: got %b want 0", acc_overflow); end
  endtask

  task automatic test_hold();
    issue(ALU_RESET, 8'h00); issue(ALU_OUT, 8'h00);
    issue(ALU_REGA, 8'h5A); issue(ALU_ADD, 8'h00);
    issue(ALU_NOP, 8'hC3); issue(ALU_REGA, 8'h33); issue(4'hE, 8'h77);
    issue(4'hC, 8'h11); issue(4'hD, 8'h22); issue(4'hF, 8'h44);
    total += 3;
    if (data_out !== 8'h00) begin bad++; $display("FAIL hold_data_out: got %h want 00", data_out); end
    if (acc_zero !== 1'b0) begin bad++; $display("FAIL hold_zero: got %b want 0", acc_zero); end
    if (acc_overflow !== 1'b0) begin bad++; $display("FAIL hold_ovf: got %b want 0", acc_overflow); end
    issue(ALU_OUT, 8'h00);
    total++;
    if (data_out !== 8'h5A) begin bad++; $display("FAIL hold_out: got %h want 5a", data_out); end
    issue(ALU_ADD, 8'h00); issue(ALU_OUT, 8'h00);
    total++;
    if (data_out !== 8'h8D) begin bad++; $display("FAIL hold_rega_loaded: got %h want 8d", data_out); end
  endtask

  task automatic test_shift_not();
    issue(ALU_RESET, 8'h00);
    issue(ALU_REGA, 8'h81); issue(ALU_ADD, 8'h00);
    issue(ALU_SHL, 8'h00);
    total++;
    if (acc_overflow !== 1'b1) begin bad++; $display("FAIL shl_ovf: got %b want 1", acc_overflow); end
    issue(ALU_OUT, 8'h00);
    total++;
    if (data_out !== 8'h02) begin bad++; $display("FAIL shl_val: got %h want 02", data_out); end
    issue(ALU_SHR, 8'h00);
    total++;
    if (acc_overflow !== 1'b0) begin bad++; $display("FAIL shr_ovf: got %b want 0", acc_overflow); end
    issue(ALU_OUT, 8'h00);
    total++;
    if (data_out !== 8'h01) begin bad++; $display("FAIL shr_val: got %h want 01", data_out); end
    issue(ALU_NOT, 8'h00); issue(ALU_OUT, 8'h00);
    total++;
    if (data_out !== 8'hFE) begin bad++; $display("FAIL not_val: got %h want fe", data_out); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++)
      issue(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset_mid();
    issue(ALU_RESET, 8'h00);
    issue(ALU_REGA, 8'hC0); issue(ALU_ADD, 8'h00); issue(ALU_ADD, 8'h00);
    issue(ALU_OUT, 8'h00);
    opcode = ALU_ADD;
    #1;
    a_reset_n = 1'b0;
    model_reset();
    #1;
    total += 3;
    if (data_out !== 8'h00) begin bad++; $display("FAIL midreset_data_out: got %h want 00", data_out); end
    if (acc_overflow !== 1'b0) begin bad++; $display("FAIL midreset_ovf: got %b want 0", acc_overflow); end
    if (acc_zero !== 1'b1) begin bad++; $display("FAIL midreset_zero: got %b want 1", acc_zero); end
    @(negedge clk);
    a_reset_n = 1'b1;
    issue(ALU_ADD, 8'h00); issue(ALU_OUT, 8'h00);
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL midreset_a_cleared: got %h want 00", data_out); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_logic_chain();
    test_borrow();
    test_carry();
    test_hold();
    test_shift_not();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit accumulator-style ALU for the SAP-1 datapath.
- Holds an operand register A, an accumulator ACC and an output register.
- A 4-bit opcode, sampled each clock, selects one of: load A, operate on ACC with A, clear, or publish ACC to the output bus.
- Zero and carry/borrow status flags feed the controller.

Parameters:
- DATA_WIDTH, 8, width of data_in, data_out, register A and ACC (must be >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- a_reset_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  operand bus, loaded into A by ALU_REGA.
- opcode  input  4  operation select, sampled on the rising clk edge.
- acc_overflow  output  1  registered carry-out (ADD) / borrow (SUB) flag.
- acc_zero  output  1  high when ACC == 0.
- data_out  output  DATA_WIDTH  output register; updated only by ALU_OUT.

Behaviour:
- One clock, clk; asynchronous active-low reset a_reset_n.
- Reset (a_reset_n low, asynchronous, any time including mid-sequence) clears:
  - A, ACC, data_out and acc_overflow to 0.
  - acc_zero therefore reads 1.
- After reset deassertion, operation resumes on the next rising edge.
- Opcode encoding:
  - 0x0 ALU_NOP
  - 0x1 ALU_RESET
  - 0x2 ALU_REGA
  - 0x3 ALU_ADD
  - 0x4 ALU_SUB
  - 0x5 ALU_AND
  - 0x6 ALU_OR
  - 0x7 ALU_XOR
  - 0x8 ALU_NOT
  - 0x9 ALU_SHL
  - 0xA ALU_SHR
  - 0xB ALU_OUT
  - 0xC-0xF reserved; behave as NOP.
- Per rising edge (single-cycle latency; result visible after the edge):
  - NOP: all state held.
  - RESET: ACC <= 0, acc_overflow <= 0. A and data_out are held.
  - REGA: A <= data_in. ACC and flags are held.
  - ADD: {carry, ACC} <= ACC + A at DATA_WIDTH+1 bits; acc_overflow <= carry. Wraps modulo 2^DATA_WIDTH.
  - SUB: ACC <= ACC - A modulo 2^DATA_WIDTH; acc_overflow <= (A > ACC), unsigned borrow.
  - AND / OR / XOR: ACC <= ACC op A; acc_overflow <= 0.
  - NOT: ACC <= ~ACC; acc_overflow <= 0.
  - SHL: ACC <= ACC << 1; acc_overflow <= old ACC MSB.
  - SHR: ACC <= ACC >> 1 (logical); acc_overflow <= old ACC LSB.
  - OUT: data_out <= ACC. ACC and flags are held.
- acc_zero is driven combinationally from the ACC register, with no extra latency.
- data_out holds its last published value until the next OUT or reset.
- No handshake: exactly one opcode is consumed per cycle.
- The opcode must be stable around the rising edge.

Decomposition:
- Shared header/package sap1_header (sap1_pkg): ALU_* opcode localparams and the 4-bit opcode width. The controller and the bench include the same definitions.
- Optional combinational sub-module alu_core: inputs ACC, A, opcode; outputs next ACC and next flag. alu owns the A, ACC, data_out and flag registers.

Test Plan:
- Reset: assert a_reset_n=0 mid-operation -> data_out=0x00, acc_overflow=0, acc_zero=1 immediately, without waiting for a clock edge.
- Logic chain, each step applied for one cycle:
  - RESET -> ACC=0x00.
  - REGA 0x0F, ADD -> ACC=0x0F.
  - REGA 0xAA, AND -> ACC=0x0A.
  - REGA 0x05, OR -> ACC=0x0F.
  - REGA 0x0F, SUB -> ACC=0x00, acc_zero=1, acc_overflow=0.
  - OUT -> data_out=0x00.
- Borrow: RESET; REGA 0x0F; ADD; REGA 0x10; SUB; OUT -> data_out=0xFF, acc_overflow=1, acc_zero=0.
- Carry: ACC=0xF0 (via REGA/ADD); REGA 0x20; ADD -> ACC=0x10, acc_overflow=1. A following AND clears acc_overflow to 0.
- Hold: with ACC=0x5A, issue NOP, REGA 0x33 and reserved 0xE -> ACC stays 0x5A, data_out unchanged, flags unchanged. A next OUT gives data_out=0x5A.
- Shift/NOT: ACC=0x81:
  - SHL -> ACC=0x02, acc_overflow=1.
  - SHR -> ACC=0x01, acc_overflow=0.
  - NOT -> ACC=0xFE.
